lector_entradas: RTL and testbench

- Input-side counterpart to the CPU output-port register: the CPU reads external 8-bit switch/key inputs through this block.
- Synchronises and debounces the asynchronous `entrada` bus.
- Each accepted change of the input value is queued as an 8-bit event in a FIFO.
- The CPU drains the FIFO with a one-cycle read strobe, reading the head combinationally.

---
 rtl/lector_entradas.sv | 97 +++++++++
 tb/tb_lector_entradas.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lector_entradas.sv
// rtl/lector_entradas.sv - synchronised, debounced 8-bit input reader with event FIFO
// Every accepted change of entrada is queued for the CPU, which pops the show-ahead head with re.
module lector_entradas #(
    parameter int DEPTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             entrada,
    input  logic                   re,
    input  logic                   clr_ovf,
    output logic [7:0]             dato,
    output logic                   vacio,
    output logic                   lleno,
    output logic [$clog2(DEPTH):0] cuenta,
    output logic                   ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);

    logic [7:0]    sync_q [SYNC_STAGES];
    logic [7:0]    s;
    logic [7:0]    candidate;
    logic [7:0]    accepted;
    logic [CW-1:0] cnt;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [7:0]    mem [DEPTH];
    logic          push;
    logic          pop;
    logic          do_write;
    logic          drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= entrada;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // An event fires once the candidate has been stable long enough and differs from the last accepted value.
    always_comb begin
        push     = (s == candidate) && (cnt == CNT_MAX) && (candidate != accepted);
        pop      = re && !vacio;
        do_write = push && (!lleno || pop);
        drop     = push && lleno && !pop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            candidate <= '0;
            cnt       <= '0;
            accepted  <= '0;
        end else if (s != candidate) begin
            candidate <= s;
            cnt       <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end else if (candidate != accepted) begin
            accepted <= candidate;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr   <= '0;
            rptr   <= '0;
            cuenta <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_write) wptr <= wptr + 1'b1;
            if (pop)      rptr <= rptr + 1'b1;
            if (do_write && !pop)      cuenta <= cuenta + 1'b1;
            else if (!do_write && pop) cuenta <= cuenta - 1'b1;
            // A fresh overflow takes priority over a coincident clear.
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wptr] <= candidate;
    end

    assign dato  = mem[rptr];
    assign vacio = (cuenta == '0);
    assign lleno = (cuenta == FULL);

endmodule

// File: tb/tb_lector_entradas.sv
// tb/tb_lector_entradas.sv - randomized and directed bench for lector_entradas
// Reference model tracks run lengths of the synchronised input and an event queue.
module tb_lector_entradas;

    localparam int DEPTH  = 16;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int LAT    = SYNC + STABLE + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       re = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] entrada = 8'h00;
    logic [7:0] dato;
    logic       vacio;
    logic       lleno;
    logic       ovf;
    logic [4:0] cuenta;

    int checks = 0;
    int errors = 0;

    lector_entradas #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .reset(reset), .entrada(entrada), .re(re), .clr_ovf(clr_ovf),
        .dato(dato), .vacio(vacio), .lleno(lleno), .cuenta(cuenta), .ovf(ovf)
    );

    always #5 clk = ~clk;

    logic [7:0] mq[$];
    logic [7:0] hist[$];
    logic [7:0] last_s;
    logic [7:0] acc;
    int         run;
    bit         m_ovf;

    // s seen at an edge is entrada sampled SYNC edges earlier; a value is accepted on its (STABLE+1)-th consecutive sighting.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq = {};
            hist = {};
            for (int i = 0; i < SYNC; i++) hist.push_back(8'h00);
            last_s = 8'h00;
            acc = 8'h00;
            run = 1;
            m_ovf = 1'b0;
        end else begin
            logic [7:0] sb;
            bit         ev, pp, full;
            sb = hist.pop_front();
            hist.push_back(entrada);
            if (sb == last_s) run++;
            else begin
                run = 1;
                last_s = sb;
            end
            ev = (run >= STABLE + 1) && (sb != acc);
            if (ev) acc = sb;
            pp = re && (mq.size() > 0);
            full = (mq.size() == DEPTH);
            if (pp) void'(mq.pop_front());
            if (ev && full && !pp) m_ovf = 1'b1;
            else begin
                if (ev) mq.push_back(sb);
                if (clr_ovf) m_ovf = 1'b0;
            end
        end
    end

    task automatic do_reset(input logic [7:0] v);
        @(negedge clk);
        reset = 1'b0;
        re = 1'b0;
        clr_ovf = 1'b0;
        entrada = v;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fill(input int first, input int n);
        for (int v = first; v < first + n; v++) begin
            entrada = 8'(v);
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({vacio, lleno, ovf, cuenta} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_state vacio=%0b lleno=%0b ovf=%0b cuenta=%0d expected 1 0 0 0", vacio, lleno, ovf, cuenta);
        end
    endtask

    task automatic test_latency();
        do_reset(8'hA5);
        for (int e = 1; e <= LAT; e++) begin
            @(negedge clk);
            checks++;
            if (vacio !== (e < LAT)) begin
                errors++;
                $display("FAIL latency_vacio edge=%0d vacio=%0b expected %0b", e, vacio, e < LAT);
            end
        end
        checks++;
        if (cuenta !== 5'd1 || dato !== 8'hA5) begin
            errors++;
            $display("FAIL latency_event cuenta=%0d dato=%h expected 1 a5", cuenta, dato);
        end
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        checks++;
        if (vacio !== 1'b1 || cuenta !== 5'd0) begin
            errors++;
            $display("FAIL latency_pop vacio=%0b cuenta=%0d expected 1 0", vacio, cuenta);
        end
    endtask

    task automatic test_glitch();
        do_reset(8'h00);
        repeat (50) @(negedge clk);
        checks++;
        if (vacio !== 1'b1) begin
            errors++;
            $display("FAIL glitch_idle vacio=%0b expected 1", vacio);
        end
        entrada = 8'h0F;
        repeat (3) @(negedge clk);
        entrada = 8'h00;
        repeat (20) @(negedge clk);
        checks++;
        if (cuenta !== 5'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL glitch_pulse cuenta=%0d ovf=%0b expected 0 0", cuenta, ovf);
        end
    endtask

    task automatic test_overflow();
        do_reset(8'h00);
        fill(1, 16);
        checks++;
        if (lleno !== 1'b1 || cuenta !== 5'd16 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full lleno=%0b cuenta=%0d ovf=%0b expected 1 16 0", lleno, cuenta, ovf);
        end
        fill(17, 1);
        checks++;
        if (ovf !== 1'b1 || cuenta !== 5'd16) begin
            errors++;
            $display("FAIL ovf_drop ovf=%0b cuenta=%0d expected 1 16", ovf, cuenta);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (vacio !== 1'b0 || dato !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_drain idx=%0d dato=%h vacio=%0b expected %h 0", i, dato, vacio, 8'(i));
            end
            re = 1'b1;
            @(negedge clk);
            re = 1'b0;
        end
        checks++;
        if (vacio !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after_drain vacio=%0b ovf=%0b expected 1 1", vacio, ovf);
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear ovf=%0b expected 0", ovf);
        end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] exp_q[$];
        do_reset(8'h00);
        fill(1, 16);
        entrada = 8'h55;
        repeat (LAT - 1) @(negedge clk);
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        checks++;
        if (cuenta !== 5'd16 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop cuenta=%0d ovf=%0b expected 16 0", cuenta, ovf);
        end
        for (int v = 2; v <= 16; v++) exp_q.push_back(8'(v));
        exp_q.push_back(8'h55);
        foreach (exp_q[i]) begin
            checks++;
            if (dato !== exp_q[i]) begin
                errors++;
                $display("FAIL full_pushpop_drain idx=%0d dato=%h expected %h", i, dato, exp_q[i]);
            end
            re = 1'b1;
            @(negedge clk);
            re = 1'b0;
        end
    endtask

    task automatic test_empty_read();
        do_reset(8'h00);
        re = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (cuenta !== 5'd0) begin
                errors++;
                $display("FAIL empty_read cycle=%0d cuenta=%0d expected 0", i, cuenta);
            end
        end
        re = 1'b0;
        entrada = 8'h3C;
        repeat (LAT) @(negedge clk);
        checks++;
        if (cuenta !== 5'd1 || dato !== 8'h3C) begin
            errors++;
            $display("FAIL empty_read_event cuenta=%0d dato=%h expected 1 3c", cuenta, dato);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(8'h00);
        fill(1, 5);
        entrada = 8'h77;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({vacio, lleno, ovf, cuenta} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_mid vacio=%0b lleno=%0b ovf=%0b cuenta=%0d expected 1 0 0 0", vacio, lleno, ovf, cuenta);
        end
        entrada = 8'h3C;
        @(negedge clk);
        reset = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        checks++;
        if (vacio !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_early vacio=%0b expected 1", vacio);
        end
        @(negedge clk);
        checks++;
        if (cuenta !== 5'd1 || dato !== 8'h3C) begin
            errors++;
            $display("FAIL reset_mid_event cuenta=%0d dato=%h expected 1 3c", cuenta, dato);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (cuenta !== 5'd1) begin
            errors++;
            $display("FAIL reset_mid_single cuenta=%0d expected 1", cuenta);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [6];
        int hold = 0;
        pool = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h3C, 8'h00};
        do_reset(8'h00);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (vacio !== (mq.size() == 0) || lleno !== (mq.size() == DEPTH) ||
                cuenta !== 5'(mq.size()) || ovf !== m_ovf ||
                (mq.size() > 0 && dato !== mq[0])) begin
                errors++;
                $display("FAIL random cyc=%0d cuenta=%0d ovf=%0b dato=%h expected cuenta=%0d ovf=%0b dato=%h",
                         i, cuenta, ovf, dato, mq.size(), m_ovf, (mq.size() > 0) ? mq[0] : 8'h00);
            end
            if (hold == 0) begin
                pool[5] = 8'($urandom);
                entrada = pool[$urandom_range(0, 5)];
                hold = $urandom_range(1, 10);
            end
            hold--;
            re = (i < 1500) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
        end
        re = 1'b0;
        clr_ovf = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_overflow();
        test_full_pushpop();
        test_empty_read();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
